// File: rtl/axi_pattern_master.sv
// AXI4 pattern master: writes a generated pattern over C_NUM_BURSTS bursts,
// then reads it back and counts data mismatches and error responses.
module axi_pattern_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_BURST_LEN        = 16,
  parameter int unsigned C_NUM_BURSTS       = 64,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE = 'h4000_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            INIT_AXI_TXN,
  input  logic [1:0]                      MODE,
  input  logic [31:0]                     SEED,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [15:0]                     ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   ERR_ADDR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned LANES = C_M_AXI_DATA_WIDTH / 32;
  localparam logic [AW-1:0] BEAT_BYTES  = AW'(BYTES);
  localparam logic [AW-1:0] BURST_BYTES = AW'(C_BURST_LEN * BYTES);
  localparam logic [8:0]    LAST_BEAT   = 9'(C_BURST_LEN - 1);
  localparam logic [12:0]   LAST_BURST  = 13'(C_NUM_BURSTS - 1);
  localparam logic [31:0]   LFSR_TAPS   = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_e;
  state_e state_q, state_d;

  logic          init_q, start;
  logic [1:0]    mode_q;
  logic [31:0]   seed_q, seed_eff, lfsr_q, lfsr_next, k_q;
  logic [8:0]    beat_q;
  logic [12:0]   burst_q;
  logic [AW-1:0] base_q, addr_q, lane_addr, err_at;
  logic          err_q;
  logic [15:0]   cnt_q;
  logic [AW-1:0] eaddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] pattern;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, beat_last, burst_last, err_ev, idle_like;

  assign start      = INIT_AXI_TXN & ~init_q;
  assign idle_like  = (state_q == IDLE) || (state_q == DONE);
  assign seed_eff   = (SEED == 32'd0) ? 32'd1 : SEED;
  assign lfsr_next  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign beat_last  = (beat_q == LAST_BEAT);
  assign burst_last = (burst_q == LAST_BURST);

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY  & M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY  & M_AXI_RVALID;

  // A bad B response is attributed to the burst base, a bad R beat to its own address.
  assign err_ev = (b_hs & (M_AXI_BRESP != 2'b00)) |
                  (r_hs & ((M_AXI_RDATA != pattern) | (M_AXI_RRESP != 2'b00) |
                           (M_AXI_RLAST != beat_last)));
  assign err_at = b_hs ? base_q : addr_q;

  always_comb begin
    pattern   = '0;
    lane_addr = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_addr = addr_q + AW'(l * 4);
      case (mode_q)
        2'd0:    pattern[l*32 +: 32] = k_q;
        2'd1:    pattern[l*32 +: 32] = 32'(lane_addr);
        2'd2:    pattern[l*32 +: 32] = lfsr_q;
        default: pattern[l*32 +: 32] = 32'd1 << k_q[4:0];
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = WR_ADDR;
      WR_ADDR:    if (aw_hs) state_d = WR_DATA;
      WR_DATA:    if (w_hs && beat_last) state_d = WR_RESP;
      WR_RESP:    if (b_hs) state_d = burst_last ? RD_ADDR : WR_ADDR;
      RD_ADDR:    if (ar_hs) state_d = RD_DATA;
      RD_DATA:    if (r_hs && beat_last) state_d = burst_last ? DONE : RD_ADDR;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    TXN_DONE      = 1'b0;
    case (state_q)
      WR_ADDR: M_AXI_AWVALID = 1'b1;
      WR_DATA: begin
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = beat_last;
      end
      WR_RESP: M_AXI_BREADY  = 1'b1;
      RD_ADDR: M_AXI_ARVALID = 1'b1;
      RD_DATA: M_AXI_RREADY  = 1'b1;
      DONE:    TXN_DONE      = 1'b1;
      default: ;
    endcase
  end

  assign M_AXI_AWADDR  = base_q;
  assign M_AXI_ARADDR  = base_q;
  assign M_AXI_AWLEN   = 8'(C_BURST_LEN - 1);
  assign M_AXI_ARLEN   = 8'(C_BURST_LEN - 1);
  assign M_AXI_AWSIZE  = 3'($clog2(BYTES));
  assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WDATA   = pattern;
  assign ERROR         = err_q;
  assign ERR_COUNT     = cnt_q;
  assign ERR_ADDR      = eaddr_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_q  <= 1'b0;
      mode_q  <= '0;
      seed_q  <= '0;
      lfsr_q  <= '0;
      k_q     <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      eaddr_q <= '0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (start && idle_like) begin
        mode_q  <= MODE;
        seed_q  <= seed_eff;
        lfsr_q  <= seed_eff;
        k_q     <= '0;
        beat_q  <= '0;
        burst_q <= '0;
        base_q  <= C_TARGET_BASE;
        addr_q  <= C_TARGET_BASE;
        err_q   <= 1'b0;
        cnt_q   <= '0;
        eaddr_q <= '0;
      end else begin
        if (w_hs || r_hs) begin
          k_q    <= k_q + 32'd1;
          lfsr_q <= lfsr_next;
          addr_q <= addr_q + BEAT_BYTES;
          beat_q <= beat_last ? '0 : beat_q + 9'd1;
        end
        // After the last write burst the generator restarts for the read-back pass.
        if (b_hs) begin
          if (burst_last) begin
            burst_q <= '0;
            base_q  <= C_TARGET_BASE;
            addr_q  <= C_TARGET_BASE;
            k_q     <= '0;
            lfsr_q  <= seed_q;
          end else begin
            burst_q <= burst_q + 13'd1;
            base_q  <= base_q + BURST_BYTES;
          end
        end
        if (r_hs && beat_last) begin
          burst_q <= burst_last ? '0 : burst_q + 13'd1;
          base_q  <= base_q + BURST_BYTES;
        end
        if (err_ev) begin
          err_q <= 1'b1;
          if (!err_q)        eaddr_q <= err_at;
          if (cnt_q != '1)   cnt_q   <= cnt_q + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_pattern_master.sv
// Bench for axi_pattern_master: a memory slave feeds a scoreboard of expected
// write/address traffic; end-of-pass status is compared with hand-computed values.
module tb_axi_pattern_master;
  localparam int unsigned BL = 16;
  localparam int unsigned NB = 4;
  localparam int unsigned BEATS = BL * NB;
  localparam logic [31:0] BASE = 32'h4000_0000;

  typedef struct packed {logic [31:0] d; logic l;} wexp_t;

  logic clk, rst_n;
  int errors = 0, checks = 0;

  // 32-bit DUT signals
  logic init, done, error;
  logic [1:0] mode;
  logic [31:0] seed, erraddr;
  logic [15:0] errcnt;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  // 128-bit DUT signals
  logic h_init, h_done, h_error;
  logic [1:0] h_mode;
  logic [31:0] h_seed, h_erraddr, h_awaddr, h_araddr;
  logic [15:0] h_errcnt;
  logic [127:0] h_wdata, h_rdata;
  logic [15:0] h_wstrb;
  logic [7:0] h_awlen, h_arlen;
  logic [2:0] h_awsize, h_arsize;
  logic [1:0] h_awburst, h_arburst, h_bresp, h_rresp;
  logic h_awvalid, h_awready, h_wlast, h_wvalid, h_wready, h_bvalid, h_bready;
  logic h_arvalid, h_arready, h_rlast, h_rvalid, h_rready;

  // scoreboard and slave knobs
  logic [31:0] exp_aw[$], exp_ar[$];
  wexp_t exp_w[$];
  logic [127:0] exp_hw[$];
  bit rand_rdy = 0, h_inj = 0;
  int bresp_err_burst = -1;
  logic [31:0] corrupt_addr = 32'd0;

  axi_pattern_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_BURST_LEN(BL),
                       .C_NUM_BURSTS(NB), .C_TARGET_BASE(BASE)) u_dut (
    .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init), .MODE(mode), .SEED(seed),
    .TXN_DONE(done), .ERROR(error), .ERR_COUNT(errcnt), .ERR_ADDR(erraddr),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready));

  axi_pattern_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(128), .C_BURST_LEN(BL),
                       .C_NUM_BURSTS(NB), .C_TARGET_BASE(BASE)) u_dut128 (
    .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(h_init), .MODE(h_mode), .SEED(h_seed),
    .TXN_DONE(h_done), .ERROR(h_error), .ERR_COUNT(h_errcnt), .ERR_ADDR(h_erraddr),
    .M_AXI_AWADDR(h_awaddr), .M_AXI_AWLEN(h_awlen), .M_AXI_AWSIZE(h_awsize),
    .M_AXI_AWBURST(h_awburst), .M_AXI_AWVALID(h_awvalid), .M_AXI_AWREADY(h_awready),
    .M_AXI_WDATA(h_wdata), .M_AXI_WSTRB(h_wstrb), .M_AXI_WLAST(h_wlast), .M_AXI_WVALID(h_wvalid),
    .M_AXI_WREADY(h_wready), .M_AXI_BRESP(h_bresp), .M_AXI_BVALID(h_bvalid),
    .M_AXI_BREADY(h_bready), .M_AXI_ARADDR(h_araddr), .M_AXI_ARLEN(h_arlen),
    .M_AXI_ARSIZE(h_arsize), .M_AXI_ARBURST(h_arburst), .M_AXI_ARVALID(h_arvalid),
    .M_AXI_ARREADY(h_arready), .M_AXI_RDATA(h_rdata), .M_AXI_RRESP(h_rresp),
    .M_AXI_RLAST(h_rlast), .M_AXI_RVALID(h_rvalid), .M_AXI_RREADY(h_rready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic logic [31:0] model_pat(input logic [1:0] m, input int unsigned k,
                                            input logic [31:0] a, input logic [31:0] lf);
    case (m)
      2'd0:    return k;
      2'd1:    return a;
      2'd2:    return lf;
      default: return 32'd1 << (k % 32);
    endcase
  endfunction

  // ---------------- 32-bit memory slave and monitor ----------------
  logic [31:0] mem[64];
  logic [31:0] w_ptr, r_ptr, aw_hold, ar_hold;
  wexp_t w_hold;
  bit b_pend, r_act, aw_pp, w_pp, ar_pp, done_chk;
  int r_cnt, w_burst, r_burst;

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rlast = 0; rdata = 0; rresp = 0;
      b_pend = 0; r_act = 0; aw_pp = 0; w_pp = 0; ar_pp = 0; done_chk = 0;
    end else begin
      if (done_chk) begin
        check("done_after_last_r", done, 1'b1);
        done_chk = 0;
      end
      if (aw_pp) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_hold});
      if (ar_pp) check("ar_stable", {arvalid, araddr}, {1'b1, ar_hold});
      if (w_pp)  check("w_stable", {wvalid, wdata, wlast}, {1'b1, w_hold.d, w_hold.l});
      // R channel
      if (r_act) begin
        if (!(rvalid && !rready)) rvalid = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        rdata = mem[r_ptr[7:2]] ^ ((r_ptr == corrupt_addr) ? 32'h1 : 32'h0);
        rlast = (r_cnt == BL - 1);
        rresp = 2'b00;
        if (rvalid && rready) begin
          if (r_cnt == BL - 1) begin
            r_act = 0;
            if (r_burst == NB - 1) begin
              check("done_before_last_r", done, 1'b0);
              done_chk = 1;
            end
          end
          r_cnt++;
          r_ptr += 4;
        end
      end else rvalid = 0;
      // AR channel
      arready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      ar_pp = arvalid && !arready;
      ar_hold = araddr;
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
        else check("ar_addr", araddr, exp_ar.pop_front());
        check("ar_fields", {arlen, arsize, arburst}, {8'd15, 3'd2, 2'd1});
        r_act = 1; r_ptr = araddr; r_cnt = 0; r_burst = int'((araddr - BASE) >> 6);
      end
      // B channel
      if (b_pend) begin
        if (!bvalid) bvalid = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        bresp = (w_burst == bresp_err_burst) ? 2'b10 : 2'b00;
      end else bvalid = 0;
      if (bvalid && bready) b_pend = 0;
      // W channel
      wready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      w_pp = wvalid && !wready;
      w_hold = '{d: wdata, l: wlast};
      if (wvalid && wready) begin
        if (exp_w.size() == 0) check("w_unexpected", 1'b1, 1'b0);
        else check("w_beat", {wdata, wlast, wstrb}, {exp_w.pop_front(), 4'hF});
        mem[w_ptr[7:2]] = wdata;
        w_ptr += 4;
        if (wlast) b_pend = 1;
      end
      // AW channel
      awready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      aw_pp = awvalid && !awready;
      aw_hold = awaddr;
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
        else check("aw_addr", awaddr, exp_aw.pop_front());
        check("aw_fields", {awlen, awsize, awburst}, {8'd15, 3'd2, 2'd1});
        w_ptr = awaddr; w_burst = int'((awaddr - BASE) >> 6);
      end
    end
  end

  // ---------------- 128-bit memory slave and monitor ----------------
  logic [127:0] hmem[64];
  logic [31:0] h_wptr, h_rptr;
  bit h_bp, h_ract;
  int h_rcnt, h_rbeat;

  always @(negedge clk) begin
    if (!rst_n) begin
      h_awready = 0; h_wready = 0; h_arready = 0; h_bvalid = 0; h_bresp = 0;
      h_rvalid = 0; h_rlast = 0; h_rdata = '0; h_rresp = 0; h_bp = 0; h_ract = 0;
    end else begin
      h_awready = 1; h_wready = 1; h_arready = 1; h_bresp = 0; h_rresp = 0;
      if (h_ract) begin
        h_rvalid = 1;
        h_rdata = hmem[h_rptr[9:4]] ^ ((h_inj && h_rbeat < 40) ? 128'h1 : 128'h0);
        h_rlast = (h_rcnt == BL - 1);
        if (h_rready) begin
          h_rptr += 16; h_rcnt++; h_rbeat++;
          if (h_rcnt == BL) h_ract = 0;
        end
      end else h_rvalid = 0;
      if (h_arvalid) begin
        h_ract = 1; h_rptr = h_araddr; h_rcnt = 0;
        if (h_araddr == BASE) h_rbeat = 0;
      end
      h_bvalid = h_bp;
      if (h_bvalid && h_bready) h_bp = 0;
      if (h_wvalid) begin
        if (exp_hw.size() == 0) check("h_w_unexpected", 1'b1, 1'b0);
        else check("h_w_beat", {h_wdata, h_wstrb}, {exp_hw.pop_front(), 16'hFFFF});
        hmem[h_wptr[9:4]] = h_wdata;
        h_wptr += 16;
        if (h_wlast) h_bp = 1;
      end
      if (h_awvalid) begin
        check("h_aw_size", h_awsize, 3'd4);
        h_wptr = h_awaddr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_pass(input logic [1:0] m, input logic [31:0] s, input bit hold);
    logic [31:0] lf;
    @(negedge clk);
    lf = (s == 0) ? 32'd1 : s;
    for (int unsigned n = 0; n < NB; n++) begin
      exp_aw.push_back(BASE + n * 64);
      exp_ar.push_back(BASE + n * 64);
    end
    for (int unsigned k = 0; k < BEATS; k++) begin
      exp_w.push_back('{d: model_pat(m, k, BASE + k * 4, lf), l: (k % BL) == BL - 1});
      lf = lfsr_step(lf);
    end
    mode = m; seed = s; init = 1;
    @(negedge clk);
    if (!hold) init = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1'b1);
  endtask

  task automatic check_status(input string name, input logic e, input logic [15:0] c,
                              input logic [31:0] a);
    check({name, "_status"}, {done, error, errcnt, erraddr}, {1'b1, e, c, a});
    check({name, "_sb_empty"}, exp_w.size() + exp_aw.size() + exp_ar.size(), 0);
  endtask

  task automatic h_start(input bit inject);
    @(negedge clk);
    for (int unsigned k = 0; k < BEATS; k++) exp_hw.push_back({4{32'd1 << (k % 32)}});
    h_inj = inject; h_init = 1;
    @(negedge clk);
    h_init = 0;
  endtask

  task automatic h_wait_done(input string name);
    int n = 0;
    while (!h_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, h_done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_d32"}, {done, error, errcnt, erraddr, awvalid, wvalid, bready, arvalid, rready}, '0);
    check({name, "_d128"}, {h_done, h_error, h_errcnt, h_erraddr, h_awvalid, h_wvalid,
                            h_bready, h_arvalid, h_rready}, '0);
  endtask

  initial begin
    int n;
    rst_n = 0; init = 0; mode = 0; seed = 0; h_init = 0; h_mode = 2'd3; h_seed = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1;

    // MODE 0, INIT held high: exactly one pass
    start_pass(2'd0, 32'd0, 1'b1);
    wait_done("t1_done");
    check_status("t1", 1'b0, 16'd0, 32'd0);
    check("t1_mem5", mem[5], 32'd5);
    repeat (20) @(negedge clk);
    check("t1_level_no_restart", {done, awvalid}, {1'b1, 1'b0});
    init = 0;

    // MODE 2, SEED 0, one corrupted read beat
    corrupt_addr = 32'h4000_0044;
    start_pass(2'd2, 32'd0, 1'b0);
    wait_done("t2_done");
    check_status("t2", 1'b1, 16'd1, 32'h4000_0044);
    check("t2_lfsr_vec", {mem[0], mem[1], mem[2]}, {32'h0000_0001, 32'h8020_0003, 32'hC030_0002});
    corrupt_addr = 32'd0;

    // MODE 1, SLVERR on burst 2
    bresp_err_burst = 2;
    start_pass(2'd1, 32'd0, 1'b0);
    wait_done("t3_done");
    check_status("t3", 1'b1, 16'd1, 32'h4000_0080);
    check("t3_mem5", mem[5], 32'h4000_0014);
    bresp_err_burst = -1;

    // MODE 3 under random back-pressure
    rand_rdy = 1;
    start_pass(2'd3, 32'd0, 1'b0);
    wait_done("t4_done");
    check_status("t4", 1'b0, 16'd0, 32'd0);
    check("t4_mem33", mem[33], 32'd2);
    rand_rdy = 0;

    // INIT pulse during RD_DATA is ignored
    start_pass(2'd0, 32'd0, 1'b0);
    n = 0;
    while (!arvalid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_ar_seen", arvalid, 1'b1);
    repeat (3) @(negedge clk);
    init = 1;
    @(negedge clk);
    init = 0;
    wait_done("t5_done");
    check_status("t5", 1'b0, 16'd0, 32'd0);
    repeat (10) @(negedge clk);
    check("t5_still_done", {done, awvalid}, {1'b1, 1'b0});

    // Reset in the middle of WR_DATA
    start_pass(2'd0, 32'd0, 1'b0);
    n = 0;
    while (!wvalid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_w_seen", wvalid, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 0;
    exp_aw.delete(); exp_ar.delete(); exp_w.delete();
    repeat (3) @(negedge clk);
    check_reset_outputs("t6_reset");
    @(posedge clk); #1 rst_n = 1;
    repeat (10) @(negedge clk);
    check("t6_idle_after_reset", {done, awvalid, arvalid}, 3'b000);
    start_pass(2'd2, 32'h1234_5678, 1'b0);
    wait_done("t6_done");
    check_status("t6", 1'b0, 16'd0, 32'd0);

    // 128-bit, MODE 3: 40 injected read errors, then a clean pass
    h_start(1'b1);
    h_wait_done("t7_done1");
    check("t7_status1", {h_error, h_errcnt, h_erraddr}, {1'b1, 16'd40, BASE});
    h_start(1'b0);
    check("t7_cleared", {h_done, h_error, h_errcnt, h_erraddr}, '0);
    h_wait_done("t7_done2");
    check("t7_status2", {h_error, h_errcnt, exp_hw.size()}, '0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_pattern_master.md
AXI_PATTERN_MASTER -- requirements
Module: axi_pattern_master

Interface
REQ-001 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, the AXI address width.
REQ-002 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, the data width; legal values are 32, 64 and 128.
REQ-003 The block SHALL have parameter C_BURST_LEN, default 16, the beats per burst; legal range is 1..256.
REQ-004 The block SHALL have parameter C_NUM_BURSTS, default 64, the bursts per pass; legal range is 1..4096.
REQ-005 The block SHALL have parameter C_TARGET_BASE, default 32'h4000_0000, the first burst byte address.
REQ-006 The block SHALL have port ACLK, input, 1 bit, the sole clock (rising edge).
REQ-007 The block SHALL have port ARESETN, input, 1 bit, reset; asynchronous, active-low.
REQ-008 The block SHALL have port INIT_AXI_TXN, input, 1 bit; a rising edge starts a pass.
REQ-009 The block SHALL have port MODE, input, 2 bits, the pattern select, sampled at start.
REQ-010 The block SHALL have port SEED, input, 32 bits, the LFSR seed, sampled at start.
REQ-011 The block SHALL have port TXN_DONE, output, 1 bit, pass complete.
REQ-012 The block SHALL have port ERROR, output, 1 bit, sticky fail flag for the pass.
REQ-013 The block SHALL have port ERR_COUNT, output, 16 bits, the saturating mismatch/response-error count.
REQ-014 The block SHALL have port ERR_ADDR, output, C_M_AXI_ADDR_WIDTH bits, the byte address of the first failing beat.
REQ-015 The block SHALL have AXI4 master write channels M_AXI_AW{ADDR,LEN,SIZE,BURST,VALID,READY}, M_AXI_W{DATA,STRB,LAST,VALID,READY} and M_AXI_B{RESP,VALID,READY}.
REQ-016 The block SHALL have AXI4 master read channels M_AXI_AR{ADDR,LEN,SIZE,BURST,VALID,READY} and M_AXI_R{DATA,RESP,LAST,VALID,READY}.
REQ-017 The block SHALL drive AxLEN = C_BURST_LEN-1, AxSIZE = log2(C_M_AXI_DATA_WIDTH/8), AxBURST = INCR and WSTRB all-ones.

Function
REQ-018 The block SHALL implement an FSM with states IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> (next burst, or RD_ADDR) -> RD_DATA -> (next burst, or DONE).
REQ-019 The block SHALL keep exactly one burst outstanding; AW/AR SHALL be issued only after the previous B or final R beat.
REQ-020 The block SHALL set the burst address to C_TARGET_BASE + n*C_BURST_LEN*(C_M_AXI_DATA_WIDTH/8), for n = 0..C_NUM_BURSTS-1.
REQ-021 Once VALID is asserted, AxVALID/WVALID SHALL hold with payload stable until READY is sampled high.
REQ-022 The block SHALL assert WLAST on beat C_BURST_LEN-1 only.
REQ-023 The block SHALL hold BREADY high in WR_RESP and RREADY high in RD_DATA.
REQ-024 The block SHALL generate pattern data per global beat index k (0-based across the pass), in each 32-bit lane, as follows:
- MODE 0: k.
- MODE 1: lane byte address.
- MODE 2: Galois LFSR x^32+x^22+x^2+x+1, seeded with SEED (a SEED of 0 is replaced by 1), advanced once per beat.
- MODE 3: 1 << (k mod 32).
REQ-025 The read pass SHALL regenerate the identical sequence, restarting the generator at k = 0 and reloading the seed.
REQ-026 The block SHALL count one error per beat with RDATA mismatch, RRESP != OKAY, or RLAST != (beat == C_BURST_LEN-1); each burst with BRESP != OKAY SHALL also add one error.
REQ-027 ERR_COUNT SHALL saturate at 16'hFFFF; ERR_ADDR SHALL capture only the first error of a pass (for a BRESP error, the burst base address).
REQ-028 On entering DONE, TXN_DONE SHALL go high one cycle after the last R handshake and SHALL hold until the next start.
REQ-029 ERROR SHALL assert in the cycle after the first error is detected and SHALL hold until the next start.
REQ-030 A rising edge on INIT_AXI_TXN in IDLE or DONE SHALL clear TXN_DONE, ERROR, ERR_COUNT and ERR_ADDR, and enter WR_ADDR the next cycle.
REQ-031 Edges on INIT_AXI_TXN in any other state SHALL be ignored.
REQ-032 The INIT_AXI_TXN edge detector SHALL be registered; a level held high SHALL start exactly one pass.

Reset
REQ-033 While ARESETN is low, all VALID/READY outputs, TXN_DONE, ERROR, ERR_COUNT and ERR_ADDR SHALL be 0, the FSM SHALL be in IDLE, and all counters SHALL be 0.
REQ-034 Reset asserted mid-burst SHALL abort immediately; after release the block SHALL wait in IDLE for a new INIT_AXI_TXN edge.

Verification
REQ-035 Test: MODE 0, C_BURST_LEN 16, C_NUM_BURSTS 4, with a memory slave -> 64 writes then 64 reads; TXN_DONE=1, ERROR=0, ERR_COUNT=0.
REQ-036 Test: MODE 2, SEED 0, with the slave corrupting the read beat at 0x4000_0044 -> ERROR=1, ERR_COUNT=1, ERR_ADDR=0x4000_0044.
REQ-037 Test: the slave returns SLVERR on the B of burst 2 (C_BURST_LEN 16, 32-bit) -> ERR_COUNT=1, ERR_ADDR=0x4000_0080, and the pass still completes.
REQ-038 Test: random READY back-pressure on all channels -> payload stable while VALID is high, WLAST on beat 15 only, pass passes.
REQ-039 Test: INIT_AXI_TXN pulse during RD_DATA -> ignored; then ARESETN low for 3 cycles mid-WR_DATA -> all outputs 0, FSM in IDLE, and a subsequent pass passes.
REQ-040 Test: MODE 3, C_M_AXI_DATA_WIDTH 128, with 40 injected errors over 2 passes -> ERR_COUNT=40 after the first pass and is cleared at the second start.
